// File: rtl/iter_shifter_pkg.sv
// iter_shifter_pkg: shared definitions for the iterative ARM operand-2 shifter.
// Holds the shift opcode and FSM state encodings, the amount clamp constants, and
// helpers that normalise the raw opcode and compute the effective step count.
package iter_shifter_pkg;

  localparam int unsigned OPND_W      = 32;  // operand width; clamp rules assume 32
  localparam int unsigned CNT_W       = 6;   // holds effective counts 0..33
  localparam int unsigned AMT_W       = 8;   // Rs[7:0]
  localparam int unsigned OP_W        = 3;
  localparam int unsigned LSX_CLAMP   = 33;  // LSL/LSR: anything past 33 behaves as 33
  localparam int unsigned ASR_CLAMP   = 32;  // ASR: anything past 32 behaves as 32
  localparam int unsigned ROR_FULL    = 32;  // ROR by a nonzero multiple of 32
  localparam int unsigned FAST_STEPS  = 4;   // bits per cycle in the fast build

  typedef enum logic [OP_W-1:0] {
    SHIFT_LSL = 3'b000,
    SHIFT_LSR = 3'b001,
    SHIFT_ASR = 3'b010,
    SHIFT_ROR = 3'b011,
    SHIFT_RRX = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Reserved opcodes 101..111 fall back to LSL.
  function automatic shift_op_e norm_op(input logic [OP_W-1:0] raw);
    shift_op_e op;
    case (raw)
      3'b001:  op = SHIFT_LSR;
      3'b010:  op = SHIFT_ASR;
      3'b011:  op = SHIFT_ROR;
      3'b100:  op = SHIFT_RRX;
      default: op = SHIFT_LSL;
    endcase
    return op;
  endfunction

  // Number of single-bit steps that reproduces the ARM register-shift result.
  function automatic logic [CNT_W-1:0] calc_eff(input shift_op_e op,
                                                input logic [AMT_W-1:0] num);
    logic [CNT_W-1:0] eff;
    eff = '0;
    case (op)
      SHIFT_LSR,
      SHIFT_LSL: eff = (num > AMT_W'(LSX_CLAMP)) ? CNT_W'(LSX_CLAMP) : CNT_W'(num);
      SHIFT_ASR: eff = (num > AMT_W'(ASR_CLAMP)) ? CNT_W'(ASR_CLAMP) : CNT_W'(num);
      SHIFT_ROR: begin
        if (num == '0)            eff = '0;
        else if (num[4:0] == '0)  eff = CNT_W'(ROR_FULL);
        else                      eff = CNT_W'(num[4:0]);
      end
      SHIFT_RRX: eff = CNT_W'(1);
      default:   eff = '0;
    endcase
    return eff;
  endfunction

endpackage

// File: rtl/iter_shifter_step.sv
// ishift_step: one single-bit shift/rotate step (combinational).
// Ports:
//   op_i       normalised shift opcode
//   data_i     current operand
//   carry_i    current carry (feeds the vacated MSB for RRX)
//   data_c_o   operand after one step
//   carry_c_o  bit shifted out by this step
module ishift_step
  import iter_shifter_pkg::*;
#(
  parameter int unsigned DATA_W = OPND_W
) (
  input  shift_op_e         op_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              carry_i,
  output logic [DATA_W-1:0] data_c_o,
  output logic              carry_c_o
);

  always_comb begin
    data_c_o  = data_i;
    carry_c_o = carry_i;
    case (op_i)
      SHIFT_LSR: begin
        carry_c_o = data_i[0];
        data_c_o  = {1'b0, data_i[DATA_W-1:1]};
      end
      SHIFT_ASR: begin
        carry_c_o = data_i[0];
        data_c_o  = {data_i[DATA_W-1], data_i[DATA_W-1:1]};
      end
      SHIFT_ROR: begin
        carry_c_o = data_i[0];
        data_c_o  = {data_i[0], data_i[DATA_W-1:1]};
      end
      SHIFT_RRX: begin
        carry_c_o = data_i[0];
        data_c_o  = {carry_i, data_i[DATA_W-1:1]};
      end
      default: begin
        carry_c_o = data_i[DATA_W-1];
        data_c_o  = {data_i[DATA_W-2:0], 1'b0};
      end
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle ARM barrel shifter for the operand-2 path.
// A start in IDLE latches the operand and carry, then RUN applies single-bit
// steps until the effective count is exhausted; DONE pulses for one cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request, accepted only in IDLE
//   shift_op          000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, others LSL
//   shift_num         shift amount Rs[7:0] (ignored for RRX)
//   shift_data        operand Rm
//   cf_in             current CPSR C flag
//   shift_out         shifted result (ALU B), held after DONE
//   shift_carry_out   shifter carry out, held after DONE
//   busy              high in RUN and DONE
//   done              one-cycle completion pulse
// Build option: define ISHIFT_FAST_EN to retire four bits per RUN cycle
// (except RRX) when at least four steps remain; results are identical.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int unsigned DATA_W = OPND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   shift_op,
  input  logic [AMT_W-1:0]  shift_num,
  input  logic [DATA_W-1:0] shift_data,
  input  logic              cf_in,
  output logic [DATA_W-1:0] shift_out,
  output logic              shift_carry_out,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  shift_op_e         op_q, op_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              carry_q, carry_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  shift_op_e         start_op;
  logic [CNT_W-1:0]  start_eff;

  assign start_op  = norm_op(shift_op);
  assign start_eff = calc_eff(start_op, shift_num);

  // Step chain: index 0 is the current register value.
`ifdef ISHIFT_FAST_EN
  localparam int unsigned N_STEPS = FAST_STEPS;
`else
  localparam int unsigned N_STEPS = 1;
`endif

  logic [DATA_W-1:0] step_data  [N_STEPS+1];
  logic              step_carry [N_STEPS+1];

  assign step_data[0]  = data_q;
  assign step_carry[0] = carry_q;

  for (genvar g = 0; g < N_STEPS; g++) begin : g_step
    ishift_step #(.DATA_W(DATA_W)) u_step (
      .op_i      (op_q),
      .data_i    (step_data[g]),
      .carry_i   (step_carry[g]),
      .data_c_o  (step_data[g+1]),
      .carry_c_o (step_carry[g+1])
    );
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= SHIFT_LSL;
      count_q <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    data_d  = data_q;
    carry_d = carry_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = shift_data;
          carry_d = cf_in;
          op_d    = start_op;
          count_d = start_eff;
          state_d = (start_eff == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
`ifdef ISHIFT_FAST_EN
        // RRX only ever runs one step, so it never takes the wide path.
        if ((count_q >= CNT_W'(FAST_STEPS)) && (op_q != SHIFT_RRX)) begin
          data_d  = step_data[FAST_STEPS];
          carry_d = step_carry[FAST_STEPS];
          count_d = count_q - CNT_W'(FAST_STEPS);
        end else begin
          data_d  = step_data[1];
          carry_d = step_carry[1];
          count_d = count_q - CNT_W'(1);
        end
`else
        data_d  = step_data[1];
        carry_d = step_carry[1];
        count_d = count_q - CNT_W'(1);
`endif
        state_d = (count_d == '0) ? ST_DONE : ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign shift_out       = data_q;
  assign shift_carry_out = carry_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed and randomized checks of iter_shifter against an
// arithmetic model of the ARM register-shift rules, including latency.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  shift_op;
  logic [7:0]  shift_num;
  logic [31:0] shift_data;
  logic        cf_in;
  logic [31:0] shift_out;
  logic        shift_carry_out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  iter_shifter dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .shift_op        (shift_op),
    .shift_num       (shift_num),
    .shift_data      (shift_data),
    .cf_in           (cf_in),
    .shift_out       (shift_out),
    .shift_carry_out (shift_carry_out),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ARM register-shift semantics written directly from the architectural rules.
  function automatic void model(input int op_raw, input int n, input logic [31:0] d,
                                input logic cf, output logic [31:0] r, output logic c,
                                output int lat);
    int op;
    int eff;
    int rr;
    op = (op_raw > 4) ? 0 : op_raw;
    r = d; c = cf; eff = 0;
    case (op)
      0: begin
        eff = (n > 33) ? 33 : n;
        if (n == 0) begin r = d; c = cf; end
        else if (n < 32) begin r = d << n; c = d[32-n]; end
        else if (n == 32) begin r = 32'h0; c = d[0]; end
        else begin r = 32'h0; c = 1'b0; end
      end
      1: begin
        eff = (n > 33) ? 33 : n;
        if (n == 0) begin r = d; c = cf; end
        else if (n < 32) begin r = d >> n; c = d[n-1]; end
        else if (n == 32) begin r = 32'h0; c = d[31]; end
        else begin r = 32'h0; c = 1'b0; end
      end
      2: begin
        eff = (n > 32) ? 32 : n;
        if (n == 0) begin r = d; c = cf; end
        else if (n < 32) begin r = 32'($signed(d) >>> n); c = d[n-1]; end
        else begin r = d[31] ? 32'hFFFF_FFFF : 32'h0; c = d[31]; end
      end
      3: begin
        rr = n % 32;
        if (n == 0) begin eff = 0; r = d; c = cf; end
        else if (rr == 0) begin eff = 32; r = d; c = d[31]; end
        else begin eff = rr; r = (d >> rr) | (d << (32 - rr)); c = d[rr-1]; end
      end
      default: begin
        eff = 1; r = {cf, d[31:1]}; c = d[0];
      end
    endcase
`ifdef ISHIFT_FAST_EN
    lat = eff / 4 + eff % 4 + 1;
`else
    lat = eff + 1;
`endif
  endfunction

  // Issue one operation, optionally pestering the DUT with ignored starts.
  task automatic run_op(input int op, input int n, input logic [31:0] d,
                        input logic cf, input bit noise);
    logic [31:0] exp_r;
    logic        exp_c;
    int          exp_lat;
    int          cyc;
    bit          seen;
    model(op, n, d, cf, exp_r, exp_c, exp_lat);
    @(negedge clk);
    start = 1'b1; shift_op = 3'(op); shift_num = 8'(n); shift_data = d; cf_in = cf;
    cyc = 0; seen = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        shift_op = 3'($urandom_range(0, 7)); shift_num = 8'($urandom);
        shift_data = $urandom; cf_in = 1'($urandom);
      end
      if (done) begin
        seen = 1;
        if (noise) start = 1'b1;
      end else begin
        check("busy_run", 32'(busy), 32'h1);
      end
    end
    if (!seen) begin
      check("done_timeout", 32'h0, 32'h1);
    end else begin
      check("latency", 32'(cyc), 32'(exp_lat));
      check("result", shift_out, exp_r);
      check("carry", 32'(shift_carry_out), 32'(exp_c));
      check("busy_done", 32'(busy), 32'h1);
    end
    @(negedge clk);
    start = 1'b0;
    check("done_low", 32'(done), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("hold_result", shift_out, exp_r);
    check("hold_carry", 32'(shift_carry_out), 32'(exp_c));
    @(negedge clk);
    check("no_second_done", 32'(done), 32'h0);
  endtask

  initial begin
    int amt;
    int pick;
    rst = 1'b0; start = 1'b0; shift_op = '0; shift_num = '0; shift_data = '0; cf_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_out", shift_out, 32'h0);
    check("rst_carry", 32'(shift_carry_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(0, 1,   32'h8000_000F, 1'b0, 0);
    run_op(0, 4,   32'h8000_000F, 1'b0, 0);
    run_op(1, 32,  32'hFFFF_FFFF, 1'b0, 0);
    run_op(1, 33,  32'hFFFF_FFFF, 1'b0, 0);
    run_op(2, 200, 32'h8000_0000, 1'b0, 0);
    run_op(3, 0,   32'h1234_5678, 1'b1, 0);
    run_op(3, 32,  32'h8000_0001, 1'b0, 0);
    run_op(3, 36,  32'h0000_000F, 1'b0, 0);
    run_op(4, 0,   32'h0000_0003, 1'b1, 0);
    run_op(0, 32,  32'h0000_0001, 1'b0, 0);
    run_op(6, 3,   32'h0000_0011, 1'b0, 0);
    run_op(0, 20,  32'hA5A5_1234, 1'b1, 1);
    run_op(4, 9,   32'h0000_0002, 1'b0, 1);

    // Reset mid-run: outputs clear at once and no done appears.
    @(negedge clk);
    start = 1'b1; shift_op = 3'd0; shift_num = 8'd20; shift_data = 32'hDEAD_BEEF; cf_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out", shift_out, 32'h0);
    check("midrst_carry", 32'(shift_carry_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'h0);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 32'h0);
    end
    run_op(0, 2, 32'h0000_0001, 1'b0, 0);

    // Randomized sweep biased toward the clamp boundaries.
    for (int i = 0; i < 60; i++) begin
      pick = int'($urandom_range(0, 7));
      case (pick)
        0: amt = 0;
        1: amt = 1;
        2: amt = 31;
        3: amt = 32;
        4: amt = 33;
        5: amt = 32 * int'($urandom_range(1, 7));
        default: amt = int'($urandom_range(0, 255));
      endcase
      run_op(int'($urandom_range(0, 7)), amt, $urandom, 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
